// File: rtl/bcd_digit_serial_ctrl.sv
// Sequencer for a shared single-digit BCD increment cell: walks an NDIG-digit
// stored value LSD first, applying +1 and stopping as soon as the carry dies.
module bcd_digit_serial_ctrl #(
  parameter int unsigned NDIG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  output logic [4*NDIG-1:0]   value,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          cell_a,
  output logic                cell_c,
  input  logic [3:0]          cell_b,
  input  logic                cell_d
);

  localparam int unsigned VW   = 4 * NDIG;
  localparam int unsigned IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [VW-1:0]   value_q, value_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic            last_digit;

  assign last_digit = (idx_q == IDXW'(NDIG - 1));

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          value_d = load_val;
          ovf_d   = 1'b0;
        end else if (start) begin
          idx_d   = '0;
          carry_d = 1'b1;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < NDIG; i++) begin
          if (idx_q == IDXW'(i)) value_d[4*i +: 4] = cell_b;
        end
        carry_d = cell_d;
        if (!cell_d || last_digit) begin
          ovf_d   = cell_d & last_digit;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Cell operands: selected digit and running carry, zero outside RUN
  always_comb begin
    cell_a = 4'd0;
    cell_c = 1'b0;
    if (state_q == ST_RUN) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (idx_q == IDXW'(i)) cell_a = value_q[4*i +: 4];
      end
      cell_c = carry_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign value    = value_q;
  assign overflow = ovf_q;
  assign busy     = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_digit_serial_ctrl.sv
// Directed bench for bcd_digit_serial_ctrl with a behavioural BCD cell model.
module tb_bcd_digit_serial_ctrl;

  localparam int unsigned NDIG = 4;
  localparam int unsigned VW   = 4 * NDIG;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          load;
  logic [VW-1:0] load_val;
  logic [VW-1:0] value;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [3:0]    cell_a;
  logic          cell_c;
  logic [3:0]    cell_b;
  logic          cell_d;

  int total = 0;
  int bad   = 0;
  int k;

  typedef struct {
    logic [VW-1:0] ld;
    logic [VW-1:0] ev;
    int            ek;
    logic          eo;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  // Reference single-digit BCD increment cell
  always_comb begin
    cell_b = 4'((int'(cell_a) + int'(cell_c)) % 10);
    cell_d = (cell_a == 4'd9) && cell_c;
  end

  bcd_digit_serial_ctrl #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load     (load),
    .load_val (load_val),
    .value    (value),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .cell_a   (cell_a),
    .cell_c   (cell_c),
    .cell_b   (cell_b),
    .cell_d   (cell_d)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [VW-1:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Issue start from IDLE, count RUN cycles, check operands and the done cycle
  task automatic run_inc(input logic [VW-1:0] base, output int cycles);
    logic [VW-1:0] b;
    b = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      if (cycles < int'(NDIG)) begin
        chk("run_cell_a", 32'(cell_a), 32'(b[4*cycles +: 4]));
        chk("run_cell_c", 32'(cell_c), 32'd1);
      end
      cycles++;
      @(negedge clk);
    end
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{16'h0129, 16'h0130, 2, 1'b0};
    vecs[1] = '{16'h9999, 16'h0000, 4, 1'b1};
    vecs[2] = '{16'h0000, 16'h0001, 1, 1'b0};
    vecs[3] = '{16'h0009, 16'h0010, 2, 1'b0};
    vecs[4] = '{16'h0099, 16'h0100, 3, 1'b0};
    vecs[5] = '{16'h0999, 16'h1000, 4, 1'b0};
    vecs[6] = '{16'h1234, 16'h1235, 1, 1'b0};
    vecs[7] = '{16'h8999, 16'h9000, 4, 1'b0};
    vecs[8] = '{16'h9899, 16'h9900, 3, 1'b0};
    vecs[9] = '{16'h0990, 16'h0991, 1, 1'b0};

    rst = 1'b1; start = 1'b0; load = 1'b0; load_val = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_value", 32'(value), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_cell_a", 32'(cell_a), 32'd0);
    chk("rst_cell_c", 32'(cell_c), 32'd0);

    // Table: load, increment, compare latency / result / overflow
    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].ld);
      chk("tbl_loaded", 32'(value), 32'(vecs[i].ld));
      run_inc(vecs[i].ld, k);
      chk("tbl_cycles", 32'(k), 32'(vecs[i].ek));
      chk("tbl_value", 32'(value), 32'(vecs[i].ev));
      chk("tbl_ovf", 32'(overflow), 32'(vecs[i].eo));
    end

    // Overflow holds in IDLE until a load clears it
    do_load(16'h9999);
    run_inc(16'h9999, k);
    @(negedge clk);
    chk("ovf_hold", 32'(overflow), 32'd1);
    chk("wrap_value", 32'(value), 32'h0000);
    do_load(16'h0000);
    chk("ovf_clr_load", 32'(overflow), 32'd0);

    // Ten back-to-back increments from zero
    for (int i = 1; i <= 10; i++) begin
      logic [VW-1:0] cur;
      cur = value;
      run_inc(cur, k);
      chk("b2b_cycles", 32'(k), (i == 10) ? 32'd2 : 32'd1);
    end
    chk("b2b_value", 32'(value), 32'h0010);

    // load wins over start in the same IDLE cycle
    load = 1'b1; start = 1'b1; load_val = 16'h0042;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("ldst_value", 32'(value), 32'h0042);
    chk("ldst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ldst_busy2", 32'(busy), 32'd0);
    chk("ldst_value2", 32'(value), 32'h0042);

    // start/load held through RUN and DONE are ignored
    do_load(16'h0999);
    start = 1'b1;
    @(negedge clk);
    load = 1'b1; load_val = 16'h5555;
    k = 0;
    while (busy && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("ign_cycles", 32'(k), 32'd4);
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_value", 32'(value), 32'h1000);
    start = 1'b0; load = 1'b0;
    @(negedge clk);
    chk("ign_value_idle", 32'(value), 32'h1000);
    chk("ign_busy_idle", 32'(busy), 32'd0);

    // Reset on the second RUN cycle discards the partial update
    do_load(16'h9999);
    run_inc(16'h9999, k);
    do_load(16'h0999);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_busy1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("mid_busy2", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_value", 32'(value), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_cell_a", 32'(cell_a), 32'd0);
    @(negedge clk);
    chk("mid_rst_nodone", 32'(done), 32'd0);
    chk("mid_rst_value2", 32'(value), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_digit_serial_ctrl.md
Name: bcd_digit_serial_ctrl

Overview:
- Sequencer for the shared single-digit BCD increment cell (4-bit digit A plus carry-in C in; 4-bit digit B plus carry-out D out).
- Holds an NDIG-digit BCD value in registers and time-multiplexes the one cell across the digits, least significant first, to perform a +1 increment.
- Stops early once the carry dies.
- Sits between the cell instance and any block that needs a multi-digit BCD counter, e.g. a display or event counter.

Parameters:
NDIG, 4, number of BCD digits held and sequenced (minimum 2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-high
start  input  1  request one +1 increment; sampled only in IDLE
load  input  1  parallel load of value; sampled only in IDLE
load_val  input  4*NDIG  value to load, digit 0 in bits [3:0]
value  output  4*NDIG  current stored value, registered
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when an increment completes
overflow  output  1  last increment carried out of the top digit
cell_a  output  4  digit presented to the cell
cell_c  output  1  carry-in presented to the cell
cell_b  input  4  cell result digit (combinational from cell_a/cell_c)
cell_d  input  1  cell carry-out

Behaviour:
- Cell contract, modelled in the bench:
  - cell_b = (cell_a + cell_c) mod 10.
  - cell_d = (cell_a == 9) & cell_c.
  - The controller writes cell_b back unchecked.
- Reset, when rst is high at a clk edge:
  - State goes to IDLE.
  - value = 0, busy = 0, done = 0, overflow = 0.
  - Digit index = 0, internal carry = 0.
  - Reset has priority over every other input, including mid-RUN. A partially updated value is discarded, so value = 0.
- States: IDLE, RUN, DONE. busy = (state == RUN). done = (state == DONE). Both are decoded from registered state.
- cell_a / cell_c:
  - In RUN: cell_a = value digit[idx], cell_c = carry (combinational from registers).
  - Outside RUN: both driven 0.
- IDLE:
  - load = 1: value <= load_val, overflow <= 0. Stay in IDLE.
  - load and start both high: load wins and start is dropped.
  - start = 1 (no load): idx <= 0, carry <= 1, overflow <= 0, go to RUN.
- RUN, each cycle:
  - digit[idx] <= cell_b, carry <= cell_d.
  - If cell_d == 0, or idx == NDIG-1: go to DONE, and overflow <= cell_d & (idx == NDIG-1).
  - Otherwise idx <= idx + 1.
  - start and load are ignored in RUN.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - start and load are ignored in DONE.
  - A new start is accepted no earlier than the cycle after done.
- Latency:
  - k = (number of trailing 9 digits) + 1, capped at NDIG.
  - start is sampled at edge 0. busy is high after edges 1..k. done is high after edge k+1.
  - Total 1 + k + 1 cycles from start to IDLE.
- Wrap-around:
  - All-9s becomes all-0s with overflow = 1.
  - overflow holds until the next load, start or reset.
- value updates digit by digit during RUN. Consumers sample value on done.

Test Plan:
1. Reset with all inputs at 0 -> value = 0, busy = 0, done = 0, overflow = 0, cell_a = 0, cell_c = 0.
2. load 0x0129 then start -> busy for 2 cycles (cell_a = 9 then 2, cell_c = 1 both cycles); done pulse with value = 0x0130, overflow = 0.
3. load 0x9999 then start -> busy for 4 cycles; value = 0x0000, overflow = 1. A following load clears overflow.
4. From 0x0000, ten back-to-back start requests, each issued the cycle after done -> value = 0x0010. Every increment takes 1 RUN cycle except the 10th, which takes 2.
5. load and start high in the same IDLE cycle with load_val = 0x0042 -> value = 0x0042, no RUN entered. start or load asserted during RUN/DONE -> ignored, value unchanged by them.
6. load 0x0999, start, assert rst on the 2nd RUN cycle -> next cycle value = 0, busy = 0, done = 0, overflow = 0, and no done pulse.
